// File: rtl/bn_res_ctrl.sv
// bn_res_ctrl: sequencer for the batch-norm + residual datapath (bn_res).
// Loads the bn_a/bn_b parameter banks from a serial word stream, then streams
// FM_DEPTH activation vectors into bn_res with a residual read issued in the
// handshake cycle, tracks vectors in flight and pulses done once all retire.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   start, load_params             job start pulse (IDLE only), load banks first
//   param_valid/ready/data         parameter word stream (all bn_a, then all bn_b)
//   par_wr_en/sel/addr/data        registered bank write port (sel 0 = bn_a)
//   act_valid, act_ready           activation vector handshake
//   res_rd_en, res_rd_addr         residual buffer read, same cycle as handshake
//   bn_valid                       bn_res data_in_valid (handshake + 1 cycle)
//   bn_out_valid                   bn_res data_out_valid (one per retired vector)
//   busy, done, err                status; err is sticky until the next start
module bn_res_ctrl #(
   parameter int unsigned PARA_WIDTH      = 16,
   parameter int unsigned CHANNEL_NUM     = 128,
   parameter int unsigned FM_DEPTH        = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   input  logic                           load_params,
   input  logic                           param_valid,
   output logic                           param_ready,
   input  logic [PARA_WIDTH-1:0]          param_data,
   output logic                           par_wr_en,
   output logic                           par_wr_sel,
   output logic [$clog2(CHANNEL_NUM)-1:0] par_wr_addr,
   output logic [PARA_WIDTH-1:0]          par_wr_data,
   input  logic                           act_valid,
   output logic                           act_ready,
   output logic                           res_rd_en,
   output logic [$clog2(FM_DEPTH)-1:0]    res_rd_addr,
   output logic                           bn_valid,
   input  logic                           bn_out_valid,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int unsigned ChW   = $clog2(CHANNEL_NUM);
   localparam int unsigned AddrW = $clog2(FM_DEPTH);
   localparam int unsigned PosW  = $clog2(FM_DEPTH + 1);
   localparam int unsigned OutW  = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StRun,
      StDrain,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic [ChW-1:0]          ch_cnt_q, ch_cnt_d;
   logic [PosW-1:0]         pos_cnt_q, pos_cnt_d;
   logic [PosW-1:0]         ret_cnt_q, ret_cnt_d;
   logic [OutW-1:0]         outst_q, outst_d;
   logic                    err_q, err_d;
   logic                    wr_en_q, wr_en_d;
   logic                    wr_sel_q, wr_sel_d;
   logic [ChW-1:0]          wr_addr_q, wr_addr_d;
   logic [PARA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    bn_valid_q;
   logic                    act_hs;
   logic                    ret_ok;

   always_comb begin
      state_d     = state_q;
      ch_cnt_d    = ch_cnt_q;
      pos_cnt_d   = pos_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      outst_d     = outst_q;
      err_d       = err_q;
      wr_en_d     = 1'b0;
      wr_sel_d    = wr_sel_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      param_ready = 1'b0;
      act_ready   = 1'b0;
      act_hs      = 1'b0;

      // A retire is only legal while vectors are actually in flight.
      ret_ok = bn_out_valid & ((state_q == StRun) | (state_q == StDrain)) &
               (outst_q != '0);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               err_d     = 1'b0;
               ch_cnt_d  = '0;
               pos_cnt_d = '0;
               ret_cnt_d = '0;
               outst_d   = '0;
               state_d   = load_params ? StLoadA : StRun;
            end
         end
         StLoadA, StLoadB: begin
            param_ready = 1'b1;
            if (param_valid) begin
               wr_en_d   = 1'b1;
               wr_sel_d  = (state_q == StLoadB);
               wr_addr_d = ch_cnt_q;
               wr_data_d = param_data;
               if (ch_cnt_q == ChW'(CHANNEL_NUM - 1)) begin
                  ch_cnt_d = '0;
                  state_d  = (state_q == StLoadA) ? StLoadB : StRun;
               end else begin
                  ch_cnt_d = ch_cnt_q + 1'b1;
               end
            end
         end
         StRun: begin
            act_ready = (outst_q < OutW'(MAX_OUTSTANDING)) & (pos_cnt_q < PosW'(FM_DEPTH));
            act_hs    = act_valid & act_ready;
            if (act_hs) begin
               pos_cnt_d = pos_cnt_q + 1'b1;
               if (pos_cnt_q == PosW'(FM_DEPTH - 1)) begin
                  state_d = StDrain;
               end
            end else if (pos_cnt_q >= PosW'(FM_DEPTH)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if ((outst_q == '0) && (ret_cnt_q == PosW'(FM_DEPTH))) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Issue and retire in the same cycle cancel out.
      unique case ({act_hs, ret_ok})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase

      if (ret_ok) begin
         ret_cnt_d = ret_cnt_q + 1'b1;
      end
      if (bn_out_valid && !ret_ok) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         ch_cnt_q   <= '0;
         pos_cnt_q  <= '0;
         ret_cnt_q  <= '0;
         outst_q    <= '0;
         err_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_sel_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         bn_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_cnt_q   <= ch_cnt_d;
         pos_cnt_q  <= pos_cnt_d;
         ret_cnt_q  <= ret_cnt_d;
         outst_q    <= outst_d;
         err_q      <= err_d;
         wr_en_q    <= wr_en_d;
         wr_sel_q   <= wr_sel_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         // Residual read has one cycle of latency, so data_in_valid trails the handshake.
         bn_valid_q <= act_hs;
      end
   end

   assign par_wr_en   = wr_en_q;
   assign par_wr_sel  = wr_sel_q;
   assign par_wr_addr = wr_addr_q;
   assign par_wr_data = wr_data_q;
   assign res_rd_en   = act_hs;
   assign res_rd_addr = pos_cnt_q[AddrW-1:0];
   assign bn_valid    = bn_valid_q;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign err         = err_q;

endmodule

// File: tb/tb_bn_res_ctrl.sv
module tb_bn_res_ctrl;

   localparam int unsigned PW = 16;
   localparam int unsigned CN = 128;
   localparam int unsigned FD = 64;
   localparam int unsigned MO = 4;

   localparam int PIdle  = 0;
   localparam int PLoadA = 1;
   localparam int PLoadB = 2;
   localparam int PRun   = 3;
   localparam int PDrain = 4;
   localparam int PDone  = 5;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b1;
   logic                   start = 1'b0;
   logic                   load_params = 1'b0;
   logic                   param_valid = 1'b0;
   logic                   param_ready;
   logic [PW-1:0]          param_data = '0;
   logic                   par_wr_en;
   logic                   par_wr_sel;
   logic [$clog2(CN)-1:0]  par_wr_addr;
   logic [PW-1:0]          par_wr_data;
   logic                   act_valid = 1'b0;
   logic                   act_ready;
   logic                   res_rd_en;
   logic [$clog2(FD)-1:0]  res_rd_addr;
   logic                   bn_valid;
   logic                   bn_out_valid = 1'b0;
   logic                   busy;
   logic                   done;
   logic                   err;

   always #5 clk = ~clk;

   bn_res_ctrl #(
      .PARA_WIDTH     (PW),
      .CHANNEL_NUM    (CN),
      .FM_DEPTH       (FD),
      .MAX_OUTSTANDING(MO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .load_params (load_params),
      .param_valid (param_valid),
      .param_ready (param_ready),
      .param_data  (param_data),
      .par_wr_en   (par_wr_en),
      .par_wr_sel  (par_wr_sel),
      .par_wr_addr (par_wr_addr),
      .par_wr_data (par_wr_data),
      .act_valid   (act_valid),
      .act_ready   (act_ready),
      .res_rd_en   (res_rd_en),
      .res_rd_addr (res_rd_addr),
      .bn_valid    (bn_valid),
      .bn_out_valid(bn_out_valid),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: job phase plus plain counts derived from the handshake rules.
   int ph, k, issued, retired, outst;
   bit err_m, exp_bn, exp_wr_en, exp_wr_sel;
   int exp_wr_addr, exp_wr_data;
   // bn_res stand-in: echoes bn_valid two cycles later when enabled.
   bit echo, bv_last;
   // Observation counters on DUT outputs.
   int cyc_n, n_wr, n_rd, n_bnv, n_done, first_bnv, last_bnv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      ph = PIdle; k = 0; issued = 0; retired = 0; outst = 0;
      err_m = 0; exp_bn = 0; exp_wr_en = 0; exp_wr_sel = 0;
      exp_wr_addr = 0; exp_wr_data = 0; bv_last = 0;
   endtask

   task automatic clear_counts();
      n_wr = 0; n_rd = 0; n_bnv = 0; n_done = 0; first_bnv = -1; last_bnv = -1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_param_ready"}, param_ready, 0);
      chk({tag, "_par_wr_en"}, par_wr_en, 0);
      chk({tag, "_par_wr_sel"}, par_wr_sel, 0);
      chk({tag, "_par_wr_addr"}, par_wr_addr, 0);
      chk({tag, "_par_wr_data"}, par_wr_data, 0);
      chk({tag, "_act_ready"}, act_ready, 0);
      chk({tag, "_res_rd_en"}, res_rd_en, 0);
      chk({tag, "_res_rd_addr"}, res_rd_addr, 0);
      chk({tag, "_bn_valid"}, bn_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // Called at a negedge with inputs already driven; checks, updates model, advances.
   task automatic cyc();
      bit exp_ar, hs_p, hs_a, legal, bad, nxt_out;
      #1;
      exp_ar = (ph == PRun) && (outst < int'(MO)) && (issued < int'(FD));
      chk("busy", busy, ph != PIdle);
      chk("done", done, ph == PDone);
      chk("param_ready", param_ready, (ph == PLoadA) || (ph == PLoadB));
      chk("act_ready", act_ready, exp_ar);
      chk("res_rd_en", res_rd_en, exp_ar && act_valid);
      chk("bn_valid", bn_valid, exp_bn);
      chk("err", err, err_m);
      chk("par_wr_en", par_wr_en, exp_wr_en);
      if (exp_wr_en) begin
         chk("par_wr_sel", par_wr_sel, exp_wr_sel);
         chk("par_wr_addr", par_wr_addr, exp_wr_addr);
         chk("par_wr_data", par_wr_data, exp_wr_data);
      end
      if (exp_ar && act_valid) chk("res_rd_addr", res_rd_addr, issued);

      if (par_wr_en) n_wr++;
      if (res_rd_en) n_rd++;
      if (done) n_done++;
      if (bn_valid) begin
         n_bnv++;
         if (first_bnv < 0) first_bnv = cyc_n;
         last_bnv = cyc_n;
      end

      hs_p  = param_valid && ((ph == PLoadA) || (ph == PLoadB));
      hs_a  = act_valid && exp_ar;
      legal = bn_out_valid && ((ph == PRun) || (ph == PDrain)) && (outst > 0);
      bad   = bn_out_valid && !legal;

      exp_wr_en = hs_p;
      if (hs_p) begin
         exp_wr_sel  = (k >= int'(CN));
         exp_wr_addr = k % int'(CN);
         exp_wr_data = int'(param_data);
      end
      exp_bn = hs_a;

      case (ph)
         PIdle: if (start) begin
            ph = load_params ? PLoadA : PRun;
            k = 0; issued = 0; retired = 0; outst = 0; err_m = 0;
         end
         PLoadA, PLoadB: if (hs_p) begin
            k++;
            if (k == int'(CN)) ph = PLoadB;
            if (k == 2 * int'(CN)) ph = PRun;
         end
         PRun: if (hs_a && (issued + 1 == int'(FD))) ph = PDrain;
         PDrain: if ((outst == 0) && (retired == int'(FD))) ph = PDone;
         PDone: ph = PIdle;
         default: ph = PIdle;
      endcase
      outst   = outst + int'(hs_a) - int'(legal);
      issued  = issued + int'(hs_a);
      retired = retired + int'(legal);
      if (bad) err_m = 1;

      nxt_out = bv_last;
      bv_last = bn_valid;
      @(negedge clk);
      cyc_n++;
      if (echo) bn_out_valid = nxt_out;
   endtask

   task automatic do_reset(input string tag);
      rstn = 1'b0;
      start = 0; load_params = 0; param_valid = 0; act_valid = 0; bn_out_valid = 0;
      echo = 0;
      #1;
      check_zero(tag);
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      clear_counts();
   endtask

   initial begin
      cyc_n = 0;
      model_clear();
      clear_counts();
      @(negedge clk);
      do_reset("reset");
      cyc();

      // Abort a load part-way through the bn_b bank.
      load_params = 1; start = 1; cyc(); start = 0; load_params = 0;
      param_valid = 1;
      for (int i = 0; i < 400 && k < int'(CN) + 60; i++) begin
         param_data = 16'h1000 + 16'(k);
         cyc();
      end
      chk("abort_writes_seen", n_wr, CN + 59);
      do_reset("mid_load_b_reset");
      cyc();

      // Full bank load, words 0x1000+i with param_valid held high.
      load_params = 1; start = 1; cyc(); start = 0; load_params = 0;
      param_valid = 1;
      for (int i = 0; i < 400 && ph != PRun; i++) begin
         param_data = 16'h1000 + 16'(k);
         cyc();
      end
      param_valid = 0;
      cyc();
      chk("load_writes", n_wr, 2 * CN);
      #1;
      chk("act_ready_after_load", act_ready, 1);

      // Full stream with act_valid held and bn_res echoing after 2 cycles.
      echo = 1; act_valid = 1;
      for (int i = 0; i < 400 && ph != PIdle; i++) cyc();
      act_valid = 0; echo = 0; bn_out_valid = 0;
      cyc();
      chk("run_bn_valid_count", n_bnv, FD);
      chk("run_back_to_back", last_bnv - first_bnv, FD - 1);
      chk("run_rd_count", n_rd, FD);
      chk("run_done_count", n_done, 1);
      chk("run_busy_after", busy, 0);
      chk("run_err_after", err, 0);

      // Withheld retires: outstanding limit, single release, simultaneous issue/retire.
      clear_counts();
      load_params = 0; start = 1; cyc(); start = 0;
      act_valid = 1;
      for (int i = 0; i < 8; i++) cyc();
      chk("withhold_issued", n_rd, MO);
      bn_out_valid = 1; cyc(); bn_out_valid = 0;
      for (int i = 0; i < 4; i++) cyc();
      chk("one_release_one_issue", n_rd, MO + 1);
      bn_out_valid = 1; cyc();
      bn_out_valid = 1; cyc();
      bn_out_valid = 0; cyc(); cyc();
      chk("simultaneous_issue_retire", n_rd, MO + 3);
      start = 1; cyc(); start = 0;
      cyc();
      chk("start_in_run_ignored", n_rd, MO + 3);

      // Randomized remainder of the job.
      for (int i = 0; i < 3000 && ph != PIdle; i++) begin
         act_valid = 1'($urandom_range(0, 1));
         bn_out_valid = ($urandom_range(0, 2) != 0) && (outst > 0) &&
                        ((ph == PRun) || (ph == PDrain));
         cyc();
      end
      act_valid = 0; bn_out_valid = 0;
      cyc();
      chk("rand_rd_count", n_rd, FD);
      chk("rand_done_count", n_done, 1);
      chk("rand_err", err, 0);

      // Randomized partial load with gapped param_valid and random words.
      load_params = 1; start = 1; cyc(); start = 0; load_params = 0;
      for (int i = 0; i < 1000 && k < 150; i++) begin
         param_valid = 1'($urandom_range(0, 1));
         param_data  = PW'($urandom);
         cyc();
      end
      do_reset("rand_load_reset");
      cyc();

      // Stray retire in IDLE sets err until the next start.
      bn_out_valid = 1; cyc(); bn_out_valid = 0;
      for (int i = 0; i < 3; i++) cyc();
      #1;
      chk("err_sticky", err, 1);
      start = 1; cyc(); start = 0;
      cyc();
      #1;
      chk("err_cleared_by_start", err, 0);
      do_reset("final_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
